pixel_writer: RTL

PIXEL_WRITER -- requirements
Module: pixel_writer

---
 rtl/vga_pkg.sv | 17 +
 rtl/pixel_fifo.sv | 48 ++++
 rtl/pixel_writer.sv | 119 +++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared screen geometry, pixel record and output FSM state encoding for pixel_writer.
package vga_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int ADDR_W   = 15;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pixel_t;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } wr_state_e;
endpackage

// File: rtl/pixel_fifo.sv
// Circular pixel FIFO of DEPTH entries (power of two); a push while full is ignored,
// even when a pop happens in the same cycle.
module pixel_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push_i,
  input  pixel_t pix_i,
  input  logic   pop_i,
  output pixel_t pix_o,
  output logic   empty_o,
  output logic   full_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  pixel_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  assign pix_o   = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= pix_i;
  end
endmodule

// File: rtl/pixel_writer.sv
// Buffers plotted pixels and writes them to a 160x120 framebuffer over a valid/ready port.
// Optional macro CLIP_STATS_EN adds a saturating clip_count output.
module pixel_writer
  import vga_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  vga_x,
  input  logic [6:0]  vga_y,
  input  logic [2:0]  vga_colour,
  input  logic        vga_plot,
  output logic        in_ready,
  output logic [14:0] mem_addr,
  output logic [2:0]  mem_data,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic        busy,
  output logic        overflow,
  output wr_state_e   dbg_state
`ifdef CLIP_STATS_EN
  ,
  output logic [15:0] clip_count
`endif
);
  // Handshake: a write transfers at a rising edge where mem_we=1 and mem_ready=1;
  // mem_we, mem_addr and mem_data stay stable until that edge.

  function automatic logic [ADDR_W-1:0] pix_addr(input pixel_t p);
    return ADDR_W'(p.y) * ADDR_W'(SCREEN_W) + ADDR_W'(p.x);
  endfunction

  pixel_t              pix_in, head;
  logic                in_range, fifo_pop, fifo_empty, fifo_full;
  wr_state_e           state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          data_q, data_d;
  logic                overflow_q;

  assign in_range = (vga_x < 8'(SCREEN_W)) && (vga_y < 7'(SCREEN_H));
  assign pix_in   = '{x: vga_x, y: vga_y, colour: vga_colour};

  pixel_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (vga_plot && in_range),
    .pix_i   (pix_in),
    .pop_i   (fifo_pop),
    .pix_o   (head),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          addr_d   = pix_addr(head);
          data_d   = head.colour;
          state_d  = WRITE;
        end
      end
      WRITE: begin
        if (mem_ready) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            addr_d   = pix_addr(head);
            data_d   = head.colour;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      data_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      overflow_q <= overflow_q | (vga_plot && in_range && fifo_full);
    end
  end

`ifdef CLIP_STATS_EN
  logic [15:0] clip_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clip_cnt_q <= '0;
    end else if (vga_plot && !in_range && (clip_cnt_q != 16'hFFFF)) begin
      clip_cnt_q <= clip_cnt_q + 16'd1;
    end
  end

  assign clip_count = clip_cnt_q;
`endif

  assign in_ready  = !fifo_full;
  assign mem_we    = (state_q == WRITE);
  assign mem_addr  = addr_q;
  assign mem_data  = data_q;
  assign busy      = !fifo_empty || mem_we;
  assign overflow  = overflow_q;
  assign dbg_state = state_q;
endmodule
